// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered 1-cycle read.
module sync_fifo_param #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int PTR           = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wren,
    input  logic [WIDTH-1:0] datain,
    output logic             wrfull,
    output logic             wrafull,
    input  logic             rden,
    output logic [WIDTH-1:0] dataout,
    output logic             rdempty,
    output logic             rdaempty,
    output logic [PTR:0]     usedw,
    input  logic             err_clr,
    output logic             ovf,
    output logic             udf
);

    localparam logic [PTR:0] FULL_CNT   = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] AFULL_CNT  = (PTR+1)'(AFULL_THRESH);
    localparam logic [PTR:0] AEMPTY_CNT = (PTR+1)'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR:0]     wr_ptr, rd_ptr;
    logic [PTR:0]     wr_ptr_nxt, rd_ptr_nxt, usedw_nxt;
    logic             wr_acc, rd_acc;

    // A full FIFO still accepts the read and an empty one still accepts the write.
    always_comb begin
        wr_acc     = wren & ~wrfull;
        rd_acc     = rden & ~rdempty;
        wr_ptr_nxt = wr_ptr + (PTR+1)'(wr_acc);
        rd_ptr_nxt = rd_ptr + (PTR+1)'(rd_acc);
        usedw_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usedw    <= '0;
            wrfull   <= 1'b0;
            wrafull  <= 1'b0;
            rdempty  <= 1'b1;
            rdaempty <= 1'b1;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            usedw    <= usedw_nxt;
            wrfull   <= (usedw_nxt == FULL_CNT);
            wrafull  <= (usedw_nxt >= AFULL_CNT);
            rdempty  <= (usedw_nxt == '0);
            rdaempty <= (usedw_nxt <= AEMPTY_CNT);
        end
    end

    // Set wins over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wren & wrfull)   ovf <= 1'b1;
            else if (err_clr)    ovf <= 1'b0;
            if (rden & rdempty)  udf <= 1'b1;
            else if (err_clr)    udf <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[PTR-1:0]] <= datain;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign dataout = rdempty ? '0 : mem[rd_ptr[PTR-1:0]];
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       dataout <= '0;
        else if (rd_acc) dataout <= mem[rd_ptr[PTR-1:0]];
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
// Handles both the standard and SYNC_FIFO_FWFT_EN read modes.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PTR   = 4;
    localparam int AFT   = 12;
    localparam int AET   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             wren = 1'b0, rden = 1'b0, err_clr = 1'b0;
    logic [WIDTH-1:0] datain = '0;
    logic [WIDTH-1:0] dataout;
    logic             wrfull, wrafull, rdempty, rdaempty, ovf, udf;
    logic [PTR:0]     usedw;

    sync_fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR),
                      .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)) dut (
        .clk(clk), .reset(reset), .wren(wren), .datain(datain),
        .wrfull(wrfull), .wrafull(wrafull), .rden(rden), .dataout(dataout),
        .rdempty(rdempty), .rdaempty(rdaempty), .usedw(usedw),
        .err_clr(err_clr), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_ovf = 1'b0, exp_udf = 1'b0;
    int               n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("usedw",    32'(usedw),    32'(n));
        check("wrfull",   32'(wrfull),   32'(n == DEPTH));
        check("wrafull",  32'(wrafull),  32'(n >= AFT));
        check("rdempty",  32'(rdempty),  32'(n == 0));
        check("rdaempty", 32'(rdaempty), 32'(n <= AET));
        check("ovf",      32'(ovf),      32'(exp_ovf));
        check("udf",      32'(udf),      32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n != 0) check("dataout", 32'(dataout), 32'(q[0]));
`else
        check("dataout", 32'(dataout), 32'(exp_dout));
`endif
    endtask

    // Drive one cycle from a negedge, advance the model at the posedge, compare at the next negedge.
    task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic c);
        bit full, empty;
        wren = w; rden = r; datain = d; err_clr = c;
        @(posedge clk);
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (r && !empty) exp_dout = q.pop_front();
        if (w && !full)  q.push_back(d);
        if (w && full)   exp_ovf = 1'b1;
        else if (c)      exp_ovf = 1'b0;
        if (r && empty)  exp_udf = 1'b1;
        else if (c)      exp_udf = 1'b0;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        wren = 1'b0; rden = 1'b0; err_clr = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    initial begin
        int pw, pr;
        // Power-on reset
        repeat (2) @(negedge clk);
        check("por_usedw", 32'(usedw), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_all();

        // Async reset mid-traffic: outputs return to reset values before any edge
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b1, 1'b1, 8'h77, 1'b0);
        idle();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("areset_usedw", 32'(usedw), 32'd0);
        check("areset_dout",  32'(dataout), 32'd0);
        check_all();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all();

        // Fill 0x01..0x10, then a rejected 17th write
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            check("fill_wrafull", 32'(wrafull), 32'(i >= AFT));
        end
        check("full_usedw", 32'(usedw), 32'd16);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_usedw", 32'(usedw), 32'd16);

        // Drain in order, extra read flags underflow, err_clr clears both
        for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            check("fwft_order", 32'(dataout), 32'(i));
`endif
            step(1'b0, 1'b1, '0, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
            check("drain_order", 32'(dataout), 32'(i));
`endif
        end
        check("drained_empty", 32'(rdempty), 32'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        check("udf_set", 32'(udf), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("err_clr", 32'({ovf, udf}), 32'd0);

        // Steady occupancy of 5 with simultaneous traffic across pointer wraps
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
        check("steady_usedw", 32'(usedw), 32'd5);
        check("steady_err", 32'({ovf, udf}), 32'd0);

        // Full + both: read wins; empty + both: write wins
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        check("refull", 32'(wrfull), 32'd1);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        check("full_both_usedw", 32'(usedw), 32'd15);
        check("full_both_ovf", 32'(ovf), 32'd1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 8'h3E, 1'b0);
        check("empty_both_usedw", 32'(usedw), 32'd1);
        check("empty_both_udf", 32'(udf), 32'd1);
        step(1'b0, 1'b1, '0, 1'b1);

`ifdef SYNC_FIFO_FWFT_EN
        // Single word falls through without a read
        step(1'b1, 1'b0, 8'h5C, 1'b0);
        check("fwft_ne", 32'(rdempty), 32'd0);
        check("fwft_word", 32'(dataout), 32'h5C);
        step(1'b0, 1'b1, '0, 1'b0);
        check("fwft_pop", 32'(rdempty), 32'd1);
`endif

        // Random traffic in phases biased towards filling, balanced, and draining
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 75 : (ph == 1) ? 50 : 25;
            pr = 100 - pw;
            for (int i = 0; i < 600; i++)
                step($urandom_range(99) < pw, $urandom_range(99) < pr,
                     8'($urandom), $urandom_range(31) == 0);
        end

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
